// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline hazard unit for the 5-stage MIPS core. It generates the stall, flush and
//   forwarding controls for the F/D, D/E, E/M and M/W pipeline registers. It also tracks
//   multi-cycle data-memory accesses with a wait/timeout FSM and keeps a saturating
//   count of stalled cycles.
//
// Ports
//   CLK, rst                 clock; asynchronous active-low reset
//   RsD, RtD, RsE, RtE       source register specifiers in D and E
//   WriteReg{E,M,W}          destination registers per stage
//   RegWrite{E,M,W}          register-write enables per stage
//   MemtoReg{E,M}            load in E / M
//   BranchD, PCSrcD          branch in D / branch resolved taken in D
//   MemReqM, MemReadyM       data-memory request in M / access completes this cycle
//   Stall{F,D,E,M}           active-high hold of PC and pipeline registers
//   Flush{D,E,W}             bubble into F/D, D/E and M/W
//   Forward{A,B}D            forward ALUOutM to the branch comparator
//   Forward{A,B}E            00 register file, 01 ResultW, 10 ALUOutM
//   MemFault                 sticky memory-timeout fault
//   StallCycles              saturating count of cycles with StallF set
module hazard_controller #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RsD,
  input  logic [ADDR_W-1:0] RtD,
  input  logic [ADDR_W-1:0] RsE,
  input  logic [ADDR_W-1:0] RtE,
  input  logic [ADDR_W-1:0] WriteRegE,
  input  logic [ADDR_W-1:0] WriteRegM,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              PCSrcD,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MemFault,
  output logic [CNT_W-1:0]  StallCycles
);

  typedef enum logic [1:0] {StIdle, StWait, StFault} state_e;

  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             memstall;
  logic             lwstall;
  logic             branchstall;
  logic             dstall;

  // Memory wait FSM. The wait counter counts the cycles the request has been pending, so the
  // request cycle itself counts as 1 on entry to StWait; with a request raised in cycle 0
  // the counter reaches MEM_TIMEOUT-1 in cycle MEM_TIMEOUT-1 and faults on the next edge.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    memstall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MemReqM && !MemReadyM) begin
          memstall   = 1'b1;
          state_d    = StWait;
          wait_cnt_d = CNT_W'(1);
        end
      end
      StWait: begin
        if (MemReadyM) begin
          state_d = StIdle;
        end else begin
          memstall = 1'b1;
          if (wait_cnt_q == WaitLast) begin
            state_d = StFault;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      StFault: begin
        memstall = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Data hazards detected in D.
  always_comb begin
    lwstall = MemtoRegE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));
    branchstall = BranchD &&
        ((RegWriteE && (WriteRegE != '0) && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
         (MemtoRegM && (WriteRegM != '0) && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    dstall = lwstall || branchstall;
  end

  // Stall / flush / forward outputs; all forced inactive while reset is asserted.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst) begin
      if (memstall) begin
        // Freeze the whole pipe and bubble M/W so the stalled M instruction retires once.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = dstall;
        StallD = dstall;
        FlushE = dstall;
      end
      // A taken branch seen while D holds re-presents itself once the stall clears.
      FlushD = PCSrcD && !StallD;

      if ((RsE != '0) && RegWriteM && (WriteRegM == RsE)) begin
        ForwardAE = 2'b10;
      end else if ((RsE != '0) && RegWriteW && (WriteRegW == RsE)) begin
        ForwardAE = 2'b01;
      end
      if ((RtE != '0) && RegWriteM && (WriteRegM == RtE)) begin
        ForwardBE = 2'b10;
      end else if ((RtE != '0) && RegWriteW && (WriteRegW == RtE)) begin
        ForwardBE = 2'b01;
      end

      ForwardAD = (RsD != '0) && RegWriteM && (WriteRegM == RsD);
      ForwardBD = (RtD != '0) && RegWriteM && (WriteRegM == RtD);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MemFault    = (state_q == StFault);
  assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 4;

  logic              CLK;
  logic              rst;
  logic [ADDR_W-1:0] RsD, RtD, RsE, RtE;
  logic [ADDR_W-1:0] WriteRegE, WriteRegM, WriteRegW;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic              MemtoRegE, MemtoRegM;
  logic              BranchD, PCSrcD;
  logic              MemReqM, MemReadyM;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushW;
  logic              ForwardAD, ForwardBD;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              MemFault;
  logic [CNT_W-1:0]  StallCycles;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_controller #(
    .ADDR_W      (ADDR_W),
    .MEM_TIMEOUT (4),
    .CNT_W       (CNT_W)
  ) u_dut (
    .CLK         (CLK),
    .rst         (rst),
    .RsD         (RsD),
    .RtD         (RtD),
    .RsE         (RsE),
    .RtE         (RtE),
    .WriteRegE   (WriteRegE),
    .WriteRegM   (WriteRegM),
    .WriteRegW   (WriteRegW),
    .RegWriteE   (RegWriteE),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .MemtoRegE   (MemtoRegE),
    .MemtoRegM   (MemtoRegM),
    .BranchD     (BranchD),
    .PCSrcD      (PCSrcD),
    .MemReqM     (MemReqM),
    .MemReadyM   (MemReadyM),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushW      (FlushW),
    .ForwardAD   (ForwardAD),
    .ForwardBD   (ForwardBD),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .MemFault    (MemFault),
    .StallCycles (StallCycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0;
    BranchD = 1'b0; PCSrcD = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic check_stalls(input string tag, input logic [3:0] stl, input logic [2:0] fl);
    check_eq({tag, ".StallF"}, StallF, stl[3]);
    check_eq({tag, ".StallD"}, StallD, stl[2]);
    check_eq({tag, ".StallE"}, StallE, stl[1]);
    check_eq({tag, ".StallM"}, StallM, stl[0]);
    check_eq({tag, ".FlushD"}, FlushD, fl[2]);
    check_eq({tag, ".FlushE"}, FlushE, fl[1]);
    check_eq({tag, ".FlushW"}, FlushW, fl[0]);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    // Hazard-causing inputs during reset must not reach the outputs.
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5; RsE = 5'd3;
    RegWriteM = 1'b1; WriteRegM = 5'd3; MemReqM = 1'b1; PCSrcD = 1'b1;
    #2;
    check_stalls("rst", 4'b0000, 3'b000);
    check_eq("rst.ForwardAE", ForwardAE, 2'b00);
    check_eq("rst.MemFault", MemFault, 1'b0);
    tick();
    check_eq("rst.StallCycles", StallCycles, 0);
    check_eq("rst.StallF_edge", StallF, 1'b0);
    clear_inputs();
    rst = 1'b1;
    tick();
    check_eq("idle.StallF", StallF, 1'b0);

    // Load-use hazard.
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    #1;
    check_stalls("lw", 4'b1100, 3'b010);
    tick();
    check_eq("lw.StallCycles", StallCycles, 1);
    RtE = 5'd0; RsD = 5'd0;
    #1;
    check_eq("lw_r0.StallF", StallF, 1'b0);
    check_eq("lw_r0.FlushE", FlushE, 1'b0);
    tick();
    check_eq("lw_r0.StallCycles", StallCycles, 1);
    clear_inputs();

    // Forwarding.
    RsE = 5'd3; RtE = 5'd7; RsD = 5'd3; RtD = 5'd0;
    RegWriteM = 1'b1; WriteRegM = 5'd3; RegWriteW = 1'b1; WriteRegW = 5'd3;
    #1;
    check_eq("fwd.AE_M", ForwardAE, 2'b10);
    check_eq("fwd.BE_none", ForwardBE, 2'b00);
    check_eq("fwd.AD", ForwardAD, 1'b1);
    check_eq("fwd.BD_r0", ForwardBD, 1'b0);
    RtE = 5'd3;
    #1;
    check_eq("fwd.BE_M", ForwardBE, 2'b10);
    RegWriteM = 1'b0;
    #1;
    check_eq("fwd.AE_W", ForwardAE, 2'b01);
    check_eq("fwd.AD_off", ForwardAD, 1'b0);
    WriteRegW = 5'd0; RsE = 5'd0;
    #1;
    check_eq("fwd.AE_r0", ForwardAE, 2'b00);
    check_eq("fwd.nostall", StallF, 1'b0);
    tick();
    clear_inputs();

    // Branch dependent on a load: 2 stall cycles, then the taken-branch flush.
    BranchD = 1'b1; PCSrcD = 1'b1; RsD = 5'd4;
    MemtoRegE = 1'b1; RtE = 5'd4; RegWriteE = 1'b1; WriteRegE = 5'd4;
    #1;
    check_stalls("br1", 4'b1100, 3'b010);
    tick();
    MemtoRegE = 1'b0; RtE = 5'd0; RegWriteE = 1'b0; WriteRegE = 5'd0;
    MemtoRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd4;
    #1;
    check_stalls("br2", 4'b1100, 3'b010);
    tick();
    MemtoRegM = 1'b0; RegWriteM = 1'b0; WriteRegM = 5'd0;
    RegWriteW = 1'b1; WriteRegW = 5'd4;
    #1;
    check_stalls("br3", 4'b0000, 3'b100);
    tick();
    check_eq("br.StallCycles", StallCycles, 3);
    clear_inputs();

    // Memory wait of 3 cycles; ready arrives when the counter hits MEM_TIMEOUT-1.
    MemReqM = 1'b1; MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    #1;
    check_stalls("mw0", 4'b1111, 3'b001);
    tick();
    MemtoRegE = 1'b0; RtE = 5'd0; RsD = 5'd0;
    #1;
    check_stalls("mw1", 4'b1111, 3'b001);
    tick();
    check_stalls("mw2", 4'b1111, 3'b001);
    tick();
    MemReadyM = 1'b1;
    #1;
    check_stalls("mw3", 4'b0000, 3'b000);
    tick();
    MemReqM = 1'b0; MemReadyM = 1'b0;
    #1;
    check_eq("mw.MemFault", MemFault, 1'b0);
    check_eq("mw.idle", StallF, 1'b0);
    check_eq("mw.StallCycles", StallCycles, 6);

    // Ready in the request cycle: no stall, stays idle.
    MemReqM = 1'b1; MemReadyM = 1'b1;
    #1;
    check_eq("mrdy.StallF", StallF, 1'b0);
    tick();
    MemReqM = 1'b0; MemReadyM = 1'b0;
    #1;
    check_eq("mrdy.idle", StallM, 1'b0);
    check_eq("mrdy.StallCycles", StallCycles, 6);

    // Timeout with MEM_TIMEOUT=4.
    MemReqM = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("to.MemFault_pre", MemFault, 1'b0);
    end
    tick();
    check_eq("to.MemFault", MemFault, 1'b1);
    MemReqM = 1'b0; MemReadyM = 1'b1;
    #1;
    check_stalls("to.fault", 4'b1111, 3'b001);
    tick();
    check_eq("to.sticky", MemFault, 1'b1);
    check_eq("to.StallCycles", StallCycles, 11);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst.MemFault", MemFault, 1'b0);
    check_eq("arst.StallCycles", StallCycles, 0);
    check_stalls("arst", 4'b0000, 3'b000);
    #2;
    rst = 1'b1;
    MemReadyM = 1'b0;
    tick();
    check_eq("post_rst.StallF", StallF, 1'b0);
    check_eq("post_rst.MemFault", MemFault, 1'b0);
    check_eq("post_rst.StallCycles", StallCycles, 0);

    // Saturation with CNT_W=4.
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    repeat (20) tick();
    check_eq("sat.StallCycles", StallCycles, 15);
    tick();
    check_eq("sat.hold", StallCycles, 15);
    check_eq("sat.StallF", StallF, 1'b1);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
